// File: rtl/gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : gpio_irq
// Brief    : N-pin bus GPIO with direction control, two-flop input sync,
//            rise/fall edge detection, W1C pending bits and level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_irq #(
    parameter int          N    = 32,
    parameter logic [31:0] BASE = 32'h0000_4000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rd,
    input  logic [31:0]   i_addr,
    input  logic          i_wr,
    input  logic [3:0]    i_wrmask,
    input  logic [31:0]   i_data,
    output logic          o_rd_valid,
    output logic          o_wr_valid,
    output logic [31:0]   o_data,
    inout  wire  [N-1:0]  gpio_inout,
    output logic          o_irq
);

    localparam logic [31:0] c_pin_mask = (N == 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << N) - 32'd1);
    localparam logic [2:0] c_reg_in      = 3'd0;
    localparam logic [2:0] c_reg_out     = 3'd1;
    localparam logic [2:0] c_reg_dir     = 3'd2;
    localparam logic [2:0] c_reg_rise_en = 3'd3;
    localparam logic [2:0] c_reg_fall_en = 3'd4;
    localparam logic [2:0] c_reg_pending = 3'd5;
    localparam logic [2:0] c_reg_out_set = 3'd6;
    localparam logic [2:0] c_reg_out_clr = 3'd7;

    logic [31:0]  r_out;
    logic [31:0]  r_dir;
    logic [31:0]  r_rise_en;
    logic [31:0]  r_fall_en;
    logic [31:0]  r_pending;
    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;
    logic [N-1:0] r_prev;
    logic         r_rd_valid;
    logic         r_wr_valid;
    logic [31:0]  r_rdata;

    logic         w_sel;
    logic         w_mapped;
    logic [2:0]   w_reg;
    logic         w_wr_en;
    logic [31:0]  w_bmask;
    logic [31:0]  w_wbits;
    logic [31:0]  w_s2;
    logic [31:0]  w_prev;
    logic [31:0]  w_rise;
    logic [31:0]  w_fall;
    logic [31:0]  w_clr;
    logic [31:0]  w_pending_nxt;
    logic [31:0]  w_rd_mux;
    logic         w_unused_addr;

    assign w_sel    = (i_addr[31:8] == BASE[31:8]);
    assign w_mapped = (i_addr[7:5] == 3'b000);
    assign w_reg    = i_addr[4:2];
    assign w_wr_en  = i_wr & w_sel & w_mapped;
    assign w_unused_addr = &{1'b0, i_addr[1:0]};

    assign w_bmask = {{8{i_wrmask[3]}}, {8{i_wrmask[2]}},
                      {8{i_wrmask[1]}}, {8{i_wrmask[0]}}};
    assign w_wbits = i_data & w_bmask & c_pin_mask;

    always_comb begin
        w_s2            = '0;
        w_prev          = '0;
        w_s2[N-1:0]     = r_s2;
        w_prev[N-1:0]   = r_prev;
    end

    // Edge set wins over a same-cycle W1C on the same bit.
    assign w_rise = w_s2 & ~w_prev & r_rise_en;
    assign w_fall = ~w_s2 & w_prev & r_fall_en;
    assign w_clr  = (w_wr_en && (w_reg == c_reg_pending)) ? w_wbits : 32'd0;
    assign w_pending_nxt = ((r_pending & ~w_clr) | w_rise | w_fall) & c_pin_mask;

    always_comb begin
        w_rd_mux = '0;
        if (w_mapped) begin
            case (w_reg)
                c_reg_in:      w_rd_mux = w_s2;
                c_reg_out:     w_rd_mux = r_out;
                c_reg_dir:     w_rd_mux = r_dir;
                c_reg_rise_en: w_rd_mux = r_rise_en;
                c_reg_fall_en: w_rd_mux = r_fall_en;
                c_reg_pending: w_rd_mux = r_pending;
                default:       w_rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_dir      <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_pending  <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_prev     <= '0;
            r_rd_valid <= 1'b0;
            r_wr_valid <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_s1       <= gpio_inout;
            r_s2       <= r_s1;
            r_prev     <= r_s2;
            r_rd_valid <= i_rd & w_sel;
            r_wr_valid <= i_wr & w_sel;
            r_rdata    <= (i_rd & w_sel) ? w_rd_mux : 32'd0;
            r_pending  <= w_pending_nxt;
            if (w_wr_en) begin
                case (w_reg)
                    c_reg_out:     r_out     <= ((r_out & ~w_bmask) | w_wbits) & c_pin_mask;
                    c_reg_dir:     r_dir     <= ((r_dir & ~w_bmask) | w_wbits) & c_pin_mask;
                    c_reg_rise_en: r_rise_en <= ((r_rise_en & ~w_bmask) | w_wbits) & c_pin_mask;
                    c_reg_fall_en: r_fall_en <= ((r_fall_en & ~w_bmask) | w_wbits) & c_pin_mask;
                    c_reg_out_set: r_out     <= r_out | w_wbits;
                    c_reg_out_clr: r_out     <= r_out & ~w_wbits;
                    default:       ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_pad
        assign gpio_inout[i] = r_dir[i] ? r_out[i] : 1'bz;
    end

    assign o_rd_valid = r_rd_valid;
    assign o_wr_valid = r_wr_valid;
    assign o_data     = r_rdata;
    assign o_irq      = |r_pending;

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_irq
// Brief    : Scoreboard bench for gpio_irq (N=8): bus map, byte masks,
//            edge detection, W1C priority, address decode and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_irq;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h0000_4000;

    localparam logic [7:0] c_in   = 8'h00;
    localparam logic [7:0] c_out  = 8'h04;
    localparam logic [7:0] c_dir  = 8'h08;
    localparam logic [7:0] c_rise = 8'h0C;
    localparam logic [7:0] c_fall = 8'h10;
    localparam logic [7:0] c_pend = 8'h14;
    localparam logic [7:0] c_set  = 8'h18;
    localparam logic [7:0] c_clr  = 8'h1C;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         rd     = 1'b0;
    logic         wr     = 1'b0;
    logic [31:0]  addr   = '0;
    logic [31:0]  wdata  = '0;
    logic [3:0]   wrmask = '0;
    logic         rd_valid;
    logic         wr_valid;
    logic [31:0]  rdata;
    logic         irq;
    wire  [N-1:0] pad;
    logic [N-1:0] drv_en  = '0;
    logic [N-1:0] drv_val = '0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] sb_q[$];
    logic exp_rd = 1'b0;
    logic exp_wr = 1'b0;

    gpio_irq #(.N(N), .BASE(BASE)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_rd       (rd),
        .i_addr     (addr),
        .i_wr       (wr),
        .i_wrmask   (wrmask),
        .i_data     (wdata),
        .o_rd_valid (rd_valid),
        .o_wr_valid (wr_valid),
        .o_data     (rdata),
        .gpio_inout (pad),
        .o_irq      (irq)
    );

    for (genvar i = 0; i < N; i++) begin : g_tb_pad
        assign pad[i] = drv_en[i] ? drv_val[i] : 1'bz;
        pulldown (pad[i]);
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic hit(input logic [31:0] a);
        return a[31:8] == BASE[31:8];
    endfunction

    // Expected strobes derived from what the bench drove on the sampling edge.
    always @(posedge clk) begin
        exp_rd <= rd & hit(addr) & ~rst;
        exp_wr <= wr & hit(addr) & ~rst;
    end

    always @(negedge clk) begin
        if (exp_rd || rd_valid) check("rd_valid", rd_valid, exp_rd);
        if (exp_wr || wr_valid) check("wr_valid", wr_valid, exp_wr);
        if (rd_valid && exp_rd && sb_q.size() > 0) check("rd_data", rdata, sb_q.pop_front());
        if (!rd_valid && exp_wr) check("data_idle", rdata, 32'd0);
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        rd = r; wr = w; addr = a; wdata = d; wrmask = m;
        sync();
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] off, input logic [31:0] d, input logic [3:0] m);
        bus(1'b0, 1'b1, BASE + {24'd0, off}, d, m);
    endtask

    task automatic rd_reg(input logic [7:0] off, input logic [31:0] exp);
        sb_q.push_back(exp);
        bus(1'b1, 1'b0, BASE + {24'd0, off}, 32'd0, 4'd0);
    endtask

    initial begin
        idle(3);
        check("reset_irq", irq, 32'd0);
        check("reset_rd_valid", rd_valid, 32'd0);
        check("reset_data", rdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) rd_reg(8'(i * 4), 32'd0);
        check("idle_irq", irq, 32'd0);

        // Output path, byte masks, set/clear, width masking
        wr_reg(c_dir, 32'h0000_00FF, 4'hF);
        wr_reg(c_out, 32'h1234_56A5, 4'b0001);
        @(negedge clk) check("pad_a5", pad, 32'h0000_00A5);
        sync();
        rd_reg(c_out, 32'h0000_00A5);
        wr_reg(c_set, 32'h0000_000A, 4'hF);
        rd_reg(c_out, 32'h0000_00AF);
        wr_reg(c_clr, 32'h0000_0081, 4'hF);
        rd_reg(c_out, 32'h0000_002E);
        wr_reg(c_out, 32'h0000_0000, 4'b0000);
        wr_reg(c_set, 32'h0000_00FF, 4'b0000);
        rd_reg(c_out, 32'h0000_002E);
        wr_reg(c_out, 32'hFFFF_FFFF, 4'hF);
        rd_reg(c_out, 32'h0000_00FF);
        idle(2);
        rd_reg(c_in, 32'h0000_00FF);

        // Simultaneous read+write returns the pre-write value
        sb_q.push_back(32'h0000_00FF);
        bus(1'b1, 1'b1, BASE + 32'h04, 32'h0000_003C, 4'hF);
        rd_reg(c_out, 32'h0000_003C);
        @(negedge clk) check("pad_3c", pad, 32'h0000_003C);
        sync();

        // Decode: IN read-only, unselected window, unmapped offset
        wr_reg(c_in, 32'h0000_0055, 4'hF);
        bus(1'b0, 1'b1, BASE + 32'h104, 32'h0000_0011, 4'hF);
        bus(1'b1, 1'b0, BASE + 32'h100, 32'd0, 4'd0);
        rd_reg(c_out, 32'h0000_003C);
        rd_reg(8'h40, 32'd0);
        rd_reg(c_set, 32'd0);

        // Input edge detection on pins 0/1 driven by the bench
        wr_reg(c_dir, 32'd0, 4'hF);
        drv_en = 8'h03;
        drv_val = 8'h00;
        wr_reg(c_rise, 32'h0000_0001, 4'hF);
        idle(3);
        drv_val[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) check("irq_k1", irq, 32'd0);
        @(negedge clk) check("irq_k2", irq, 32'd1);
        sync();
        rd_reg(c_pend, 32'h0000_0001);
        rd_reg(c_in, 32'h0000_0001);

        wr_reg(c_pend, 32'h0000_0001, 4'hF);
        @(negedge clk) check("irq_w1c", irq, 32'd0);
        sync();
        rd_reg(c_pend, 32'd0);

        drv_val[0] = 1'b0;
        idle(4);
        rd_reg(c_pend, 32'd0);

        wr_reg(c_fall, 32'h0000_0001, 4'hF);
        wr_reg(c_rise, 32'd0, 4'hF);
        drv_val[0] = 1'b1;
        idle(4);
        rd_reg(c_pend, 32'd0);
        drv_val[0] = 1'b0;
        idle(4);
        rd_reg(c_pend, 32'h0000_0001);
        check("irq_fall", irq, 32'd1);

        wr_reg(c_fall, 32'd0, 4'hF);
        idle(2);
        rd_reg(c_pend, 32'h0000_0001);
        wr_reg(c_pend, 32'h0000_0001, 4'b0000);
        rd_reg(c_pend, 32'h0000_0001);
        wr_reg(c_pend, 32'h0000_0001, 4'b0001);
        rd_reg(c_pend, 32'd0);

        // W1C coincident with a new rise on pin0: pin1 clears, pin0 stays
        wr_reg(c_rise, 32'h0000_0003, 4'hF);
        drv_val = 8'h03;
        idle(4);
        rd_reg(c_pend, 32'h0000_0003);
        drv_val[0] = 1'b0;
        idle(4);
        drv_val[0] = 1'b1;
        idle(2);
        wr_reg(c_pend, 32'h0000_0003, 4'hF);
        rd_reg(c_pend, 32'h0000_0001);
        check("irq_race", irq, 32'd1);

        // Reset with outputs driven, PENDING=0x03 and a read in flight
        drv_val = 8'h00;
        idle(4);
        drv_val = 8'h03;
        idle(4);
        rd_reg(c_pend, 32'h0000_0003);
        drv_en = 8'h00;
        idle(2);
        wr_reg(c_dir, 32'h0000_00FF, 4'hF);
        @(negedge clk) check("pad_pre_rst", pad, 32'h0000_003C);
        sync();
        sb_q.push_back(32'h0000_0003);
        rd = 1'b1; addr = BASE + 32'h14;
        sync();
        rst = 1'b1;
        sync();
        rd = 1'b0;
        check("rst_rd_valid", rd_valid, 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_irq", irq, 32'd0);
        check("rst_pad", pad, 32'd0);
        sync();
        rst = 1'b0;
        rd_reg(c_dir, 32'd0);
        rd_reg(c_pend, 32'd0);
        rd_reg(c_out, 32'd0);
        rd_reg(c_rise, 32'd0);
        rd_reg(c_in, 32'd0);
        check("post_rst_irq", irq, 32'd0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) sync();
        if (sb_q.size() != 0) check("sb_drain", sb_q.size(), 32'd0);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_irq.md
# gpio_irq

Parametrised GPIO peripheral for the SoC memory bus. It generalises the fixed 32-bit GPIO to N pins and adds per-pin direction, two-flop input synchronisation, rising/falling edge detection, sticky write-1-to-clear pending bits and a level interrupt output. It sits on the shared CPU bus beside ram/timer/gpi/gpo; its read data and valid strobes are OR-combined at the top level, so all bus outputs are zero when not addressed.

## Interface
- N, 32: number of pins, 1..32; register bits [31:N] read 0 and ignore writes.
- BASE, 32'h0000_4000: byte address of register window, 256-byte aligned.
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- i_rd  input  1  bus read request, one-cycle pulse.
- i_addr  input  32  bus byte address; bits [1:0] ignored.
- i_wr  input  1  bus write request, one-cycle pulse.
- i_wrmask  input  4  byte-lane enables for writes; bit k covers data[8k+7:8k].
- i_data  input  32  write data.
- o_rd_valid  output  1  read response strobe.
- o_wr_valid  output  1  write acknowledge strobe.
- o_data  output  32  read data; 0 whenever o_rd_valid is 0.
- gpio_inout  inout  N  pads; bit driven from OUT when DIR bit is 1, else high-Z.
- o_irq  output  1  level interrupt, high while any PENDING bit is set.

## Operation
- Selected when i_addr[31:8] == BASE[31:8]. Offsets (word): 0x00 IN (RO), 0x04 OUT (RW), 0x08 DIR (RW, 1 = output), 0x0C RISE_EN (RW), 0x10 FALL_EN (RW), 0x14 PENDING (read; write-1-to-clear), 0x18 OUT_SET (WO, OUT |= data), 0x1C OUT_CLR (WO, OUT &= ~data).
- Writes honour i_wrmask per byte for RW, W1C, SET and CLR registers; masked-off bytes unchanged / no effect.
- Reads of RO-zero or write-only offsets (0x18, 0x1C, 0x20..0xFC) return 0; writes to IN and unmapped offsets ignored; both still acknowledged.
- Unselected address: no strobe, o_data 0, no state change.
- Input path: s1 <= pad, s2 <= s1, prev <= s2. IN reads s2 (output pins read back their driven value via the pad).
- rise = s2 & ~prev & RISE_EN; fall = ~s2 & prev & FALL_EN; PENDING <= (PENDING & ~clr) | rise | fall. Set has priority over a same-cycle W1C on the same bit.
- Disabling an edge enable does not clear existing PENDING bits.
- o_irq = |PENDING[N-1:0], driven from registers (no combinational path from bus inputs).
- i_rd and i_wr both high in the same cycle: write performed, both strobes asserted next cycle, o_data carries the pre-write value.

## Timing
- Request sampled at rising edge k; o_rd_valid/o_wr_valid high for exactly one cycle after edge k; o_data valid in that same cycle. Back-to-back requests every cycle supported, no stalls.
- Register write visible on pads and in readback one cycle after edge k.
- Pad level stable before edge k: s1 at k, s2 (IN) at k+1, PENDING and o_irq set after k+2.
- Pulses shorter than one clock may be missed; no glitch filtering.
- Reset (synchronous, any cycle, including mid-transaction): OUT, DIR, RISE_EN, FALL_EN, PENDING, s1, s2, prev = 0; o_rd_valid, o_wr_valid = 0; o_data = 0; o_irq = 0; all pads high-Z. A request coincident with rst is dropped (no strobe). Because prev resets to 0 and enables to 0, no spurious pending after reset release.

## Test plan
- Reset then read all offsets 0x00..0x1C with pads pulled low -> every read returns 0, o_rd_valid one cycle after each request, o_irq 0.
- N=8: write DIR=0xFF, OUT=0xA5 with mask 4'b0001 -> pads 0xA5 next cycle; OUT_SET 0x0A -> OUT 0xAF; OUT_CLR 0x81 -> OUT 0x2E; write OUT=0xFFFF_FFFF -> read back 0x0000_00FF.
- RISE_EN=0x01, pad0 low->high before edge k -> IN bit0 = 1 after k+1, PENDING=0x01 and o_irq=1 after k+2; no pending on falling edge; FALL_EN=0x01 then falling edge -> still 0x01.
- W1C 0x01 to PENDING in same cycle a new rising edge on pin0 is detected -> PENDING stays 0x01; W1C on a quiet cycle -> PENDING 0, o_irq 0 next cycle.
- Write with i_addr = BASE+0x100 -> no o_wr_valid, no register change; read at BASE+0x40 -> o_rd_valid=1, o_data=0.
- Assert rst while DIR=0xFF, PENDING=0x03 and a read in flight -> next cycle all outputs 0, pads high-Z, no read strobe.
